// File: rtl/filter_rx.sv
// Receive-side decoder for a Filter stream: re-joins the early MSB with the
// shifted body, then buffers {parity, word} in a small FIFO with a ready/valid head.
module filter_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    io_x_data,
    input  logic                     io_x_valid,
    input  logic                     io_x_parity,
    output logic [DATA_WIDTH-1:0]    io_y_data,
    output logic                     io_y_parity,
    output logic                     io_y_valid,
    input  logic                     io_y_ready,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_overflow,
    output logic [CNT_WIDTH-1:0]     io_drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic                  msb_q;
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    logic                  full, empty, pop, push, full_eff, wr_en, drop;
    logic [DATA_WIDTH:0]   wr_entry;

    // The Filter emits a word's MSB one cycle ahead of its shifted body.
    assign wr_entry = {io_x_data[0], msb_q, io_x_data[DATA_WIDTH-1:1]};

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop      = io_y_valid && io_y_ready;
    assign push     = io_x_valid;
    assign full_eff = full && !pop;
    assign wr_en    = push && !full_eff;
    assign drop     = push && full_eff;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msb_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            msb_q      <= io_x_parity;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Entries are cleared on reset so an empty FIFO presents zeros at its head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    assign io_y_data     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign io_y_parity   = mem_q[rd_ptr_q][DATA_WIDTH];
    assign io_y_valid    = !empty;
    assign io_count      = count_q;
    assign io_overflow   = overflow_q;
    assign io_drop_count = drop_q;

endmodule

// File: tb/tb_filter_rx.sv
// Bench for filter_rx: an upstream Filter encoder is emulated in the bench and the
// decoded FIFO output is compared against a queue of the original words.
module tb_filter_rx;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] io_x_data = '0;
    logic          io_x_valid = 1'b0;
    logic          io_x_parity = 1'b0;
    logic          io_y_ready = 1'b0;

    logic [DW-1:0] y_data_a, y_data_b;
    logic          y_par_a, y_par_b, y_valid_a, y_valid_b, ovf_a, ovf_b;
    logic [2:0]    count_a, count_b;
    logic [7:0]    drop_a;
    logic [1:0]    drop_b;

    always #5 clk = ~clk;

    filter_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset),
        .io_x_data(io_x_data), .io_x_valid(io_x_valid), .io_x_parity(io_x_parity),
        .io_y_data(y_data_a), .io_y_parity(y_par_a), .io_y_valid(y_valid_a),
        .io_y_ready(io_y_ready), .io_count(count_a), .io_overflow(ovf_a),
        .io_drop_count(drop_a)
    );

    filter_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .io_x_data(io_x_data), .io_x_valid(io_x_valid), .io_x_parity(io_x_parity),
        .io_y_data(y_data_b), .io_y_parity(y_par_b), .io_y_valid(y_valid_b),
        .io_y_ready(io_y_ready), .io_count(count_b), .io_overflow(ovf_b),
        .io_drop_count(drop_b)
    );

    // Reference: queue of original {parity, word} plus a plain drop tally.
    logic [DW:0] q[$];
    int          drops = 0;
    bit          enc_v = 1'b0;
    logic [DW:0] enc_orig = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("y_valid_a", 32'(y_valid_a), 32'(sz > 0));
        chk("y_valid_b", 32'(y_valid_b), 32'(sz > 0));
        chk("count_a", 32'(count_a), 32'(sz));
        chk("count_b", 32'(count_b), 32'(sz));
        if (sz > 0) begin
            chk("y_data_a", 32'(y_data_a), 32'(q[0][DW-1:0]));
            chk("y_par_a", 32'(y_par_a), 32'(q[0][DW]));
            chk("y_data_b", 32'(y_data_b), 32'(q[0][DW-1:0]));
            chk("y_par_b", 32'(y_par_b), 32'(q[0][DW]));
        end
        chk("overflow_a", 32'(ovf_a), 32'(drops > 0));
        chk("overflow_b", 32'(ovf_b), 32'(drops > 0));
        chk("drop_cnt8", 32'(drop_a), 32'((drops > 255) ? 255 : drops));
        chk("drop_cnt2", 32'(drop_b), 32'((drops > 3) ? 3 : drops));
    endtask

    // One clock: the Filter accepts (fw, fp) if fv, and emits the previously
    // accepted word's shifted body; MSB-out is junk when nothing is accepted.
    task automatic cyc(input bit fv, input logic [DW-1:0] fw, input bit fp, input bit rdy);
        bit pop;
        io_y_ready  = rdy;
        io_x_parity = fv ? fw[DW-1] : 1'($urandom);
        io_x_valid  = enc_v;
        io_x_data   = enc_v ? {enc_orig[DW-2:0], enc_orig[DW]} : DW'($urandom);
        pop = (q.size() > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (enc_v) begin
            if (q.size() < DEPTH) q.push_back(enc_orig);
            else drops++;
        end
        enc_v    = fv;
        enc_orig = {fp, fw};
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        io_x_valid = 1'b0;
        io_y_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        drops = 0;
        enc_v = 1'b0;
        check_all();
        chk("rst_y_data", 32'(y_data_a), 32'h0);
        chk("rst_y_par", 32'(y_par_a), 32'h0);
    endtask

    initial begin
        logic [DW-1:0] chain_w [4];
        chain_w = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};

        #1;
        do_reset();
        cyc(0, '0, 0, 0);

        // Round trip: valid at output two cycles after Filter accepts the word.
        cyc(1, 16'hA5C3, 1, 1);
        cyc(0, '0, 0, 1);
        chk("rt_data", 32'(y_data_a), 32'hA5C3);
        chk("rt_par", 32'(y_par_a), 32'h1);
        cyc(0, '0, 0, 1);

        // Back-to-back stream with alternating parity.
        for (int i = 0; i < 4; i++) cyc(1, chain_w[i], i[0], 1);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1);

        // Backpressure: fill, then drain.
        for (int i = 0; i < 4; i++) cyc(1, 16'h1000 + 16'(i), i[0], 0);
        cyc(0, '0, 0, 0);
        chk("bp_count", 32'(count_a), 32'd4);
        chk("bp_head", 32'(y_data_a), 32'h1000);
        chk("bp_drops", 32'(drop_a), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1);
        chk("bp_empty", 32'(y_valid_a), 32'h0);

        // Overflow: 4 fill + 3 dropped.
        for (int i = 0; i < 7; i++) cyc(1, 16'h2000 + 16'(i), ~i[0], 0);
        cyc(0, '0, 0, 0);
        chk("ovf_flag", 32'(ovf_a), 32'h1);
        chk("ovf_drops", 32'(drop_a), 32'd3);
        chk("ovf_head", 32'(y_data_a), 32'h2000);
        // Push while full with a simultaneous pop is accepted.
        cyc(1, 16'h3333, 1, 0);
        cyc(0, '0, 0, 1);
        chk("full_pp_drops", 32'(drop_a), 32'd3);
        chk("full_pp_count", 32'(count_a), 32'd4);
        // Two more drops: 5 total, 2-bit counter saturates.
        cyc(1, 16'h4444, 0, 0);
        cyc(1, 16'h5555, 1, 0);
        cyc(0, '0, 0, 0);
        chk("sat_drop8", 32'(drop_a), 32'd5);
        chk("sat_drop2", 32'(drop_b), 32'd3);

        // Reset mid-operation with 2 entries and overflow set.
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 1);
        chk("pre_rst_count", 32'(count_a), 32'd2);
        do_reset();
        chk("mid_rst_ovf", 32'(ovf_a), 32'h0);
        cyc(1, 16'h00FF, 0, 1);
        cyc(0, '0, 0, 1);
        chk("post_rst_data", 32'(y_data_a), 32'h00FF);
        cyc(0, '0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7), DW'($urandom), 1'($urandom),
                ($urandom_range(0, 9) < 4));
        end
        for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/filter_rx.md
Name: filter_rx

Overview:
- Receive-side companion of the Filter stage. Undoes the one-bit left-shift/parity-insert encoding of a Filter stream and recovers the original data word and parity bit.
- Buffers recovered words in a small FIFO that has a ready/valid output.
- Sits at the tail of a Filter/FilterBlock chain. The upstream side has no backpressure, so FIFO overflow is counted and reported, never stalled.

Parameters:
- DATA_WIDTH, 16, width of the data word; must match the Filter stage.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- io_x_data  in  DATA_WIDTH  encoded data from Filter: {orig[DATA_WIDTH-2:0], orig_parity}; this is the registered output.
- io_x_valid  in  1  encoded word valid (Filter's registered output).
- io_x_parity  in  1  Filter's combinational MSB-out: bit DATA_WIDTH-1 of the word Filter accepts this cycle.
- io_y_data  out  DATA_WIDTH  recovered word at FIFO head.
- io_y_parity  out  1  recovered parity bit at FIFO head.
- io_y_valid  out  1  FIFO not empty.
- io_y_ready  in  1  consumer accepts the head word.
- io_count  out  log2(DEPTH)+1  current FIFO occupancy.
- io_overflow  out  1  sticky flag: at least one word was dropped since reset.
- io_drop_count  out  CNT_WIDTH  saturating count of dropped words.

Behaviour:
- Decode alignment:
  - Filter emits the MSB of word n combinationally in the same cycle it accepts word n. It emits the shifted body of word n one cycle later.
  - The block therefore holds msb_q, a register that captures io_x_parity every cycle, regardless of valid.
- Decode: in a cycle where io_x_valid=1:
  - word = {msb_q, io_x_data[DATA_WIDTH-1:1]}
  - par = io_x_data[0]
- Push: push = io_x_valid. A word is written when push && !full_eff, where full_eff = full && !(pop).
- Pop: pop = io_y_valid && io_y_ready. The head is removed at the clock edge.
- Simultaneous push and pop:
  - When full: both succeed; occupancy is unchanged and nothing is dropped.
  - When empty: only the push takes effect. There is no bypass, so io_y_valid rises the next cycle.
- Latency: a word presented (io_x_valid) in cycle c appears at io_y_* in cycle c+1 at the earliest (1 cycle), assuming the FIFO was empty.
- Ordering: strict FIFO. io_y_data and io_y_parity are driven from storage, with no combinational path from io_x_*.
- Storage: DEPTH-entry circular buffer of {par, word}. Read and write pointers wrap modulo DEPTH. Full and empty are derived from io_count (0 = empty, DEPTH = full).
- Overflow: when push && full_eff, the incoming word is discarded and the FIFO is unchanged.
  - io_overflow is set and stays 1 until reset.
  - io_drop_count increments and saturates at 2^CNT_WIDTH-1 (no wrap).
- Pop when empty: ignored, since io_y_valid=0 makes pop false. The pointers do not move.
- Reset, effective at the next edge, including mid-stream:
  - msb_q=0, pointers=0, io_count=0.
  - io_y_valid=0, io_overflow=0, io_drop_count=0.
  - io_y_data and io_y_parity read 0, because storage entries are cleared to 0.
  - Any word in flight during reset is lost.
- The first valid word after reset decodes with msb_q taken from io_x_parity in the previous (non-reset) cycle. If the stream starts in the first cycle after reset, the MSB decodes as 0.

Test Plan:
- Round trip: Filter→filter_rx, ready=1. Filter input 0xA5C3 with parity 1 in cycle 0. Filter outputs data 0x4B87 in cycle 1 with io_x_parity=1 in cycle 0. Required: io_y_valid=1, io_y_data=0xA5C3, io_y_parity=1 in cycle 2.
- Chain: FilterBlock (two stages) feeds two cascaded decoders, tail decoder last. Send words 0x0001, 0x8000, 0xFFFF, 0x1234 with alternating parity. Required: identical words and parity, in order.
- Backpressure: ready=0 with 4 valid words pushed. Required: io_count=4, io_y_data = first word, no drops. Then ready=1 for 4 cycles. Required: the 4 words in order, then io_y_valid=0.
- Overflow: FIFO full, ready=0, 3 more words pushed. Required: io_overflow=1, io_drop_count=3, stored contents unchanged. Next, push while full with ready=1 in the same cycle. Required: accepted, io_drop_count stays 3.
- Saturation: CNT_WIDTH=2, 5 drops. Required: io_drop_count=3.
- Reset mid-operation: reset asserted for one cycle with 2 entries and overflow set. Required: next cycle io_count=0, io_y_valid=0, io_overflow=0, io_drop_count=0. Then a new word 0x00FF decodes correctly.
